// File: rtl/uart_tx.sv
// -----------------------------------------------------------------------------
// uart_tx -- asynchronous serial transmitter (start, data LSB first, optional
// parity, 1..2 stop bits). Bit timing is taken from an external baud clock
// that is only sampled in the clk domain; a rising edge of clk_bd gives one
// baud tick.
//
// Parameters
//   DATA_BITS  : data bits per frame (5..8)
//   PARITY_EN  : 1 inserts a parity bit after the data bits
//   PARITY_ODD : 1 selects odd parity, 0 even (only used with PARITY_EN=1)
//   STOP_BITS  : number of stop bits (1..2)
//
// Ports
//   clk      : system clock
//   rst      : synchronous active-high reset
//   clk_bd   : baud clock, sampled as data
//   tx_start : frame request, accepted only while idle
//   tx_data  : frame payload, captured on acceptance
//   tx       : registered serial line, idle high
//   tx_busy  : high while a frame is in progress
//   tx_done  : one-cycle pulse when the last stop bit has completed
// -----------------------------------------------------------------------------
module uart_tx #(
  parameter int DATA_BITS  = 8,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0,
  parameter int STOP_BITS  = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clk_bd,
  input  logic                 tx_start,
  input  logic [DATA_BITS-1:0] tx_data,
  output logic                 tx,
  output logic                 tx_busy,
  output logic                 tx_done
);

  localparam int IDX_W = $clog2(DATA_BITS);
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(DATA_BITS - 1);
  localparam logic             STOP_LAST = 1'(STOP_BITS - 1);
  localparam logic             ODD_BIT   = 1'(PARITY_ODD);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_SYNC   = 3'd1;
  localparam logic [2:0] S_START  = 3'd2;
  localparam logic [2:0] S_DATA   = 3'd3;
  localparam logic [2:0] S_PARITY = 3'd4;
  localparam logic [2:0] S_STOP   = 3'd5;

  logic [2:0]           state_q,    state_d;
  logic                 tx_q,       tx_d;
  logic                 tx_done_q,  tx_done_d;
  logic [IDX_W-1:0]     bit_idx_q,  bit_idx_d;
  logic                 stop_cnt_q, stop_cnt_d;
  logic [DATA_BITS-1:0] shift_q,    shift_d;
  logic                 parity_q,   parity_d;
  logic                 clk_bd_q;
  logic                 tick;

  // Rising edge of the sampled baud clock. clk_bd_q resets high so a baud
  // clock that is already high when reset is released is not seen as an edge.
  assign tick = clk_bd & ~clk_bd_q;

  always_comb begin
    state_d    = state_q;
    tx_d       = tx_q;
    tx_done_d  = 1'b0;
    bit_idx_d  = bit_idx_q;
    stop_cnt_d = stop_cnt_q;
    shift_d    = shift_q;
    parity_d   = parity_q;

    case (state_q)
      S_IDLE: begin
        if (tx_start) begin
          shift_d    = tx_data;
          // Parity is taken from the captured payload, so later changes on
          // tx_data cannot leak into the frame.
          parity_d   = (^tx_data) ^ ODD_BIT;
          bit_idx_d  = '0;
          stop_cnt_d = 1'b0;
          state_d    = S_SYNC;
        end
      end
      // Waiting for a baud edge keeps the start bit exactly one period long.
      S_SYNC: begin
        if (tick) begin
          tx_d    = 1'b0;
          state_d = S_START;
        end
      end
      S_START: begin
        if (tick) begin
          tx_d      = shift_q[0];
          bit_idx_d = '0;
          state_d   = S_DATA;
        end
      end
      S_DATA: begin
        if (tick) begin
          if (bit_idx_q != LAST_IDX) begin
            // The bit on the line is always shift_q[0]; shifting right puts
            // the next one there.
            bit_idx_d = bit_idx_q + 1'b1;
            tx_d      = shift_q[1];
            shift_d   = shift_q >> 1;
          end else if (PARITY_EN != 0) begin
            tx_d    = parity_q;
            state_d = S_PARITY;
          end else begin
            tx_d       = 1'b1;
            stop_cnt_d = 1'b0;
            state_d    = S_STOP;
          end
        end
      end
      S_PARITY: begin
        if (tick) begin
          tx_d       = 1'b1;
          stop_cnt_d = 1'b0;
          state_d    = S_STOP;
        end
      end
      S_STOP: begin
        if (tick) begin
          if (stop_cnt_q != STOP_LAST) begin
            stop_cnt_d = stop_cnt_q + 1'b1;
          end else begin
            // Back in IDLE during the tx_done cycle, so a pending request is
            // taken immediately and frames can run back to back.
            state_d   = S_IDLE;
            tx_done_d = 1'b1;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
        tx_d    = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      tx_q       <= 1'b1;
      tx_done_q  <= 1'b0;
      bit_idx_q  <= '0;
      stop_cnt_q <= 1'b0;
      shift_q    <= '0;
      parity_q   <= 1'b0;
      clk_bd_q   <= 1'b1;
    end else begin
      state_q    <= state_d;
      tx_q       <= tx_d;
      tx_done_q  <= tx_done_d;
      bit_idx_q  <= bit_idx_d;
      stop_cnt_q <= stop_cnt_d;
      shift_q    <= shift_d;
      parity_q   <= parity_d;
      clk_bd_q   <= clk_bd;
    end
  end

  assign tx      = tx_q;
  assign tx_done = tx_done_q;
  assign tx_busy = (state_q != S_IDLE);

endmodule
